// File: rtl/taxi_axi_if.sv
// AXI4 write-path interface bundle (AW, W, B) with master and slave modports.
interface taxi_axi_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int STRB_W    = DATA_W / 8,
    parameter int ID_W      = 8,
    parameter bit AWUSER_EN = 1'b0,
    parameter int AWUSER_W  = 1,
    parameter bit WUSER_EN  = 1'b0,
    parameter int WUSER_W   = 1,
    parameter bit BUSER_EN  = 1'b0,
    parameter int BUSER_W   = 1
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic [AWUSER_W-1:0] awuser;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
    logic                wlast;
    logic [WUSER_W-1:0]  wuser;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic [BUSER_W-1:0]  buser;
    logic                bvalid;
    logic                bready;

    modport wr_mst (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready
    );

    modport wr_slv (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready
    );
endinterface

// File: rtl/taxi_axi_pipe_wr.sv
// AXI4 write-path pipeline: per-channel bypass/simple/skid stages on AW, W, B
// plus an optional outstanding-write limiter gating AW acceptance.
module taxi_axi_pipe_wr_stage #(
    parameter int REG_TYPE = 1,
    parameter int W        = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    if (REG_TYPE == 0) begin : g_bypass
        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
    end else if (REG_TYPE == 1) begin : g_simple
        logic [W-1:0] data_r;
        logic         valid_r;
        logic         ready_r;
        logic         load_s;
        logic         valid_next_s;

        // single entry: fills on an input beat, drains on an output beat
        always_comb begin
            load_s = in_valid && ready_r;
            if (load_s) begin
                valid_next_s = 1'b1;
            end else if (out_ready) begin
                valid_next_s = 1'b0;
            end else begin
                valid_next_s = valid_r;
            end
        end

        // occupancy, registered ready and payload
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                ready_r <= 1'b0;
                data_r  <= {W{1'b0}};
            end else begin
                valid_r <= valid_next_s;
                ready_r <= !valid_next_s;
                if (load_s) begin
                    data_r <= in_data;
                end
            end
        end

        assign out_data  = data_r;
        assign out_valid = valid_r;
        assign in_ready  = ready_r;
    end else if (REG_TYPE == 2) begin : g_skid
        logic [W-1:0] out_data_r;
        logic [W-1:0] skid_data_r;
        logic         out_valid_r;
        logic         skid_valid_r;
        logic         ready_r;
        logic         out_valid_next_s;
        logic         skid_valid_next_s;
        logic         load_out_in_s;
        logic         load_skid_s;
        logic         load_out_skid_s;

        // ready_r high implies an empty skid, so an input beat lands in the
        // output register if it is free, otherwise in the skid register
        always_comb begin
            out_valid_next_s  = out_valid_r;
            skid_valid_next_s = skid_valid_r;
            load_out_in_s     = 1'b0;
            load_skid_s       = 1'b0;
            load_out_skid_s   = 1'b0;
            if (ready_r) begin
                if (out_ready || !out_valid_r) begin
                    out_valid_next_s = in_valid;
                    load_out_in_s    = 1'b1;
                end else begin
                    skid_valid_next_s = in_valid;
                    load_skid_s       = 1'b1;
                end
            end else if (out_ready) begin
                out_valid_next_s  = skid_valid_r;
                skid_valid_next_s = 1'b0;
                load_out_skid_s   = 1'b1;
            end else begin
                out_valid_next_s  = out_valid_r;
                skid_valid_next_s = skid_valid_r;
            end
        end

        // output/skid registers and registered ready
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_r  <= 1'b0;
                skid_valid_r <= 1'b0;
                ready_r      <= 1'b0;
                out_data_r   <= {W{1'b0}};
                skid_data_r  <= {W{1'b0}};
            end else begin
                out_valid_r  <= out_valid_next_s;
                skid_valid_r <= skid_valid_next_s;
                ready_r      <= !skid_valid_next_s;
                if (load_out_in_s) begin
                    out_data_r <= in_data;
                end else if (load_out_skid_s) begin
                    out_data_r <= skid_data_r;
                end
                if (load_skid_s) begin
                    skid_data_r <= in_data;
                end
            end
        end

        assign out_data  = out_data_r;
        assign out_valid = out_valid_r;
        assign in_ready  = ready_r;
    end else begin : g_bad_type
        $fatal(0, "taxi_axi_pipe_wr_stage: REG_TYPE must be 0, 1 or 2");
    end
endmodule

module taxi_axi_pipe_wr #(
    parameter int AW_REG_TYPE     = 1,
    parameter int W_REG_TYPE      = 2,
    parameter int B_REG_TYPE      = 1,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axi_if.wr_slv       s_axi_wr,
    taxi_axi_if.wr_mst       m_axi_wr,
    output logic [CNT_W-1:0] outstanding,
    output logic             at_limit
);
    localparam int ADDR_W    = s_axi_wr.ADDR_W;
    localparam int ID_W      = s_axi_wr.ID_W;
    localparam int DATA_W    = s_axi_wr.DATA_W;
    localparam int STRB_W    = s_axi_wr.STRB_W;
    localparam bit AWUSER_EN = s_axi_wr.AWUSER_EN && m_axi_wr.AWUSER_EN;
    localparam bit WUSER_EN  = s_axi_wr.WUSER_EN && m_axi_wr.WUSER_EN;
    localparam bit BUSER_EN  = s_axi_wr.BUSER_EN && m_axi_wr.BUSER_EN;
    localparam int AWUSER_W  = s_axi_wr.AWUSER_W;
    localparam int WUSER_W   = s_axi_wr.WUSER_W;
    localparam int BUSER_W   = s_axi_wr.BUSER_W;
    localparam int AW_PW     = ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + AWUSER_W;
    localparam int W_PW      = DATA_W + STRB_W + 1 + WUSER_W;
    localparam int B_PW      = ID_W + 2 + BUSER_W;

    if (s_axi_wr.DATA_W != m_axi_wr.DATA_W) begin : g_chk_data
        $fatal(0, "taxi_axi_pipe_wr: DATA_W differs between interfaces");
    end
    if (s_axi_wr.STRB_W != m_axi_wr.STRB_W) begin : g_chk_strb
        $fatal(0, "taxi_axi_pipe_wr: STRB_W differs between interfaces");
    end

    logic [AWUSER_W-1:0] aw_user_in_s;
    logic [AWUSER_W-1:0] aw_user_out_s;
    logic [WUSER_W-1:0]  w_user_in_s;
    logic [WUSER_W-1:0]  w_user_out_s;
    logic [BUSER_W-1:0]  b_user_in_s;
    logic [BUSER_W-1:0]  b_user_out_s;
    logic [AW_PW-1:0]    aw_in_s;
    logic [AW_PW-1:0]    aw_out_s;
    logic [W_PW-1:0]     w_in_s;
    logic [W_PW-1:0]     w_out_s;
    logic [B_PW-1:0]     b_in_s;
    logic [B_PW-1:0]     b_out_s;
    logic                aw_stage_valid_s;
    logic                aw_stage_ready_s;
    logic                aw_hs_s;
    logic                b_hs_s;
    logic [CNT_W-1:0]    cnt_s;
    logic                lim_s;

    // user sidebands travel only when both ends carry them
    if (AWUSER_EN) begin : g_awuser
        assign aw_user_in_s = s_axi_wr.awuser;
    end else begin : g_no_awuser
        assign aw_user_in_s = {AWUSER_W{1'b0}};
    end
    if (WUSER_EN) begin : g_wuser
        assign w_user_in_s = s_axi_wr.wuser;
    end else begin : g_no_wuser
        assign w_user_in_s = {WUSER_W{1'b0}};
    end
    if (BUSER_EN) begin : g_buser
        assign b_user_in_s = m_axi_wr.buser;
    end else begin : g_no_buser
        assign b_user_in_s = {BUSER_W{1'b0}};
    end

    assign aw_in_s = {s_axi_wr.awid, s_axi_wr.awaddr, s_axi_wr.awlen, s_axi_wr.awsize,
                      s_axi_wr.awburst, s_axi_wr.awlock, s_axi_wr.awcache, s_axi_wr.awprot,
                      s_axi_wr.awqos, s_axi_wr.awregion, aw_user_in_s};
    assign {m_axi_wr.awid, m_axi_wr.awaddr, m_axi_wr.awlen, m_axi_wr.awsize,
            m_axi_wr.awburst, m_axi_wr.awlock, m_axi_wr.awcache, m_axi_wr.awprot,
            m_axi_wr.awqos, m_axi_wr.awregion, aw_user_out_s} = aw_out_s;
    assign m_axi_wr.awuser = aw_user_out_s;

    assign w_in_s = {s_axi_wr.wdata, s_axi_wr.wstrb, s_axi_wr.wlast, w_user_in_s};
    assign {m_axi_wr.wdata, m_axi_wr.wstrb, m_axi_wr.wlast, w_user_out_s} = w_out_s;
    assign m_axi_wr.wuser = w_user_out_s;

    assign b_in_s = {m_axi_wr.bid, m_axi_wr.bresp, b_user_in_s};
    assign {s_axi_wr.bid, s_axi_wr.bresp, b_user_out_s} = b_out_s;
    assign s_axi_wr.buser = b_user_out_s;

    // at the limit the AW stage never sees a valid beat and upstream sees no ready
    assign aw_stage_valid_s  = s_axi_wr.awvalid && !lim_s;
    assign s_axi_wr.awready  = aw_stage_ready_s && !lim_s;
    assign aw_hs_s           = s_axi_wr.awvalid && s_axi_wr.awready;
    assign b_hs_s            = s_axi_wr.bvalid && s_axi_wr.bready;

    taxi_axi_pipe_wr_stage #(.REG_TYPE(AW_REG_TYPE), .W(AW_PW)) aw_stage (
        .clk(clk), .rst_n(rst_n),
        .in_data(aw_in_s), .in_valid(aw_stage_valid_s), .in_ready(aw_stage_ready_s),
        .out_data(aw_out_s), .out_valid(m_axi_wr.awvalid), .out_ready(m_axi_wr.awready)
    );

    taxi_axi_pipe_wr_stage #(.REG_TYPE(W_REG_TYPE), .W(W_PW)) w_stage (
        .clk(clk), .rst_n(rst_n),
        .in_data(w_in_s), .in_valid(s_axi_wr.wvalid), .in_ready(s_axi_wr.wready),
        .out_data(w_out_s), .out_valid(m_axi_wr.wvalid), .out_ready(m_axi_wr.wready)
    );

    taxi_axi_pipe_wr_stage #(.REG_TYPE(B_REG_TYPE), .W(B_PW)) b_stage (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_s), .in_valid(m_axi_wr.bvalid), .in_ready(m_axi_wr.bready),
        .out_data(b_out_s), .out_valid(s_axi_wr.bvalid), .out_ready(s_axi_wr.bready)
    );

    if (MAX_OUTSTANDING > 0) begin : g_limiter
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_next_s;
        logic             lim_r;

        // accepted AW adds, returned B removes; a B at zero is ignored
        always_comb begin
            cnt_next_s = cnt_r;
            case ({aw_hs_s, b_hs_s})
                2'b10: cnt_next_s = cnt_r + CNT_W'(1);
                2'b01: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_next_s = cnt_r - CNT_W'(1);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                default: cnt_next_s = cnt_r;
            endcase
        end

        // count and limit flag, both registered so freed slots show next cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= {CNT_W{1'b0}};
                lim_r <= 1'b0;
            end else begin
                cnt_r <= cnt_next_s;
                lim_r <= (cnt_next_s == CNT_W'(MAX_OUTSTANDING));
            end
        end

        assign cnt_s = cnt_r;
        assign lim_s = lim_r;
    end else begin : g_no_limiter
        assign cnt_s = {CNT_W{1'b0}};
        assign lim_s = 1'b0;
    end

    assign outstanding = cnt_s;
    assign at_limit    = lim_s;
endmodule

// File: tb/tb_taxi_axi_pipe_wr.sv
// Directed bench: bypass/simple stages via a vector table, then limiter,
// skid backpressure and mid-stream reset sequences.
module tb_taxi_axi_pipe_wr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    taxi_axi_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) s0 (), m0 ();
    taxi_axi_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .AWUSER_EN(1'b1), .AWUSER_W(4)) s1 (), m1 ();

    logic [2:0] outstanding0;
    logic       at_limit0;
    logic [0:0] outstanding1;
    logic       at_limit1;

    taxi_axi_pipe_wr #(.AW_REG_TYPE(1), .W_REG_TYPE(2), .B_REG_TYPE(1), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_axi_wr(s0), .m_axi_wr(m0),
        .outstanding(outstanding0), .at_limit(at_limit0)
    );

    taxi_axi_pipe_wr #(.AW_REG_TYPE(0), .W_REG_TYPE(1), .B_REG_TYPE(0), .MAX_OUTSTANDING(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axi_wr(s1), .m_axi_wr(m1),
        .outstanding(outstanding1), .at_limit(at_limit1)
    );

    typedef struct {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [3:0]  awuser;
        logic        m_awready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic        s_bready;
        logic        e_awvalid;
        logic [31:0] e_awaddr;
        logic [3:0]  e_awuser;
        logic        e_awready;
        logic        e_bvalid;
        logic [1:0]  e_bresp;
        logic        e_bready;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic init_inputs();
        s0.awid = 4'h0; s0.awaddr = 32'h0; s0.awlen = 8'h0; s0.awsize = 3'h2; s0.awburst = 2'b01;
        s0.awlock = 1'b0; s0.awcache = 4'h0; s0.awprot = 3'h0; s0.awqos = 4'h0; s0.awregion = 4'h0;
        s0.awuser = 1'b0; s0.awvalid = 1'b0; s0.wdata = 32'h0; s0.wstrb = 4'hf; s0.wlast = 1'b1;
        s0.wuser = 1'b0; s0.wvalid = 1'b0; s0.bready = 1'b0;
        m0.awready = 1'b0; m0.wready = 1'b0; m0.bid = 4'h0; m0.bresp = 2'b00; m0.buser = 1'b0; m0.bvalid = 1'b0;
        s1.awid = 4'h0; s1.awaddr = 32'h0; s1.awlen = 8'h0; s1.awsize = 3'h2; s1.awburst = 2'b01;
        s1.awlock = 1'b0; s1.awcache = 4'h0; s1.awprot = 3'h0; s1.awqos = 4'h0; s1.awregion = 4'h0;
        s1.awuser = 4'h0; s1.awvalid = 1'b0; s1.wdata = 32'h0; s1.wstrb = 4'hf; s1.wlast = 1'b1;
        s1.wuser = 1'b0; s1.wvalid = 1'b0; s1.bready = 1'b0;
        m1.awready = 1'b0; m1.wready = 1'b0; m1.bid = 4'h0; m1.bresp = 2'b00; m1.buser = 1'b0; m1.bvalid = 1'b0;
    endtask

    // offer one B beat on dut's m side until its B stage takes it
    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        logic ok;
        ok = 1'b0;
        m0.bvalid = 1'b1; m0.bid = id; m0.bresp = resp;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (m0.bready) begin
                ok = 1'b1;
                break;
            end
        end
        #1 m0.bvalid = 1'b0;
        if (!ok) chk("push_b_timeout", ok, 1'b1);
    endtask

    // wait for an s-side B handshake on dut, recording AW acceptance on that edge
    task automatic wait_s_b(output logic found, output logic aw_at, output logic [3:0] id, output logic [1:0] resp);
        found = 1'b0; aw_at = 1'b0; id = 4'h0; resp = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (s0.bvalid && s0.bready) begin
                found = 1'b1;
                aw_at = s0.awvalid && s0.awready;
                id = s0.bid;
                resp = s0.bresp;
                break;
            end
        end
        #1;
        chk("s_b_handshake_seen", found, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found, aw_at, a_hs, m_hs, in_hs, out_hs, both, rd;
        logic [3:0] bid;
        logic [1:0] bresp;
        logic [31:0] od;
        int sent, got, acc, macc, b2b, comb_viol;

        vecs[0] = '{1'b1, 32'h1000_0000, 4'h3, 1'b1, 1'b0, 2'b00, 1'b1,
                    1'b1, 32'h1000_0000, 4'h3, 1'b1, 1'b0, 2'b00, 1'b1};
        vecs[1] = '{1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 2'b11, 1'b0,
                    1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 2'b11, 1'b0};
        vecs[2] = '{1'b1, 32'hDEAD_BEEF, 4'hA, 1'b0, 1'b1, 2'b01, 1'b1,
                    1'b1, 32'hDEAD_BEEF, 4'hA, 1'b0, 1'b1, 2'b01, 1'b1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 1'b1, 1'b0, 2'b10, 1'b0,
                    1'b0, 32'hFFFF_FFFC, 4'hF, 1'b1, 1'b0, 2'b10, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0004, 4'h5, 1'b1, 1'b1, 2'b00, 1'b1,
                    1'b1, 32'h0000_0004, 4'h5, 1'b1, 1'b1, 2'b00, 1'b1};

        init_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_awvalid", m0.awvalid, 1'b0);
        chk("rst_m_wvalid", m0.wvalid, 1'b0);
        chk("rst_s_bvalid", s0.bvalid, 1'b0);
        chk("rst_s_awready", s0.awready, 1'b0);
        chk("rst_s_wready", s0.wready, 1'b0);
        chk("rst_m_bready", m0.bready, 1'b0);
        chk("rst_outstanding", outstanding0, 3'd0);
        chk("rst_at_limit", at_limit0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_awready", s0.awready, 1'b1);
        chk("post_rst_s_wready", s0.wready, 1'b1);
        chk("post_rst_m_bready", m0.bready, 1'b1);
        chk("post_rst_s1_wready", s1.wready, 1'b1);

        // combinational passthrough of bypass AW/B on dut_b
        for (int i = 0; i < 5; i++) begin
            s1.awvalid = vecs[i].awvalid; s1.awaddr = vecs[i].awaddr; s1.awuser = vecs[i].awuser;
            m1.awready = vecs[i].m_awready; m1.bvalid = vecs[i].bvalid; m1.bresp = vecs[i].bresp;
            s1.bready = vecs[i].s_bready;
            #2;
            chk("vec_m_awvalid", m1.awvalid, vecs[i].e_awvalid);
            chk("vec_m_awaddr", m1.awaddr, vecs[i].e_awaddr);
            chk("vec_m_awuser", m1.awuser, vecs[i].e_awuser);
            chk("vec_s_awready", s1.awready, vecs[i].e_awready);
            chk("vec_s_bvalid", s1.bvalid, vecs[i].e_bvalid);
            chk("vec_s_bresp", s1.bresp, vecs[i].e_bresp);
            chk("vec_m_bready", m1.bready, vecs[i].e_bready);
        end
        chk("unlimited_outstanding", outstanding1, 1'b0);
        chk("unlimited_at_limit", at_limit1, 1'b0);
        s1.awvalid = 1'b0; m1.bvalid = 1'b0;

        // simple W stage: one beat per two cycles, in order
        @(posedge clk);
        #1;
        s1.wvalid = 1'b1; m1.wready = 1'b1; s1.wdata = 32'd0;
        sent = 0; got = 0; b2b = 0; rd = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            in_hs = s1.wvalid && s1.wready;
            out_hs = m1.wvalid && m1.wready;
            od = m1.wdata;
            if (in_hs && rd) b2b++;
            rd = in_hs;
            if (out_hs) begin
                chk("w1_order", od, got);
                got++;
            end
            if (in_hs) sent++;
            #1 s1.wdata = sent;
        end
        s1.wvalid = 1'b0;
        chk("w1_accepted", sent, 6);
        chk("w1_delivered", got, 6);
        chk("w1_back_to_back", b2b, 0);

        // B at zero count must not underflow
        s0.bready = 1'b1;
        push_b(4'h1, 2'b10);
        wait_s_b(found, aw_at, bid, bresp);
        chk("underflow_outstanding", outstanding0, 3'd0);
        chk("b_id", bid, 4'h1);
        chk("b_resp", bresp, 2'b10);

        // limiter: hold AW valid with B withheld, only 4 get through
        m0.awready = 1'b1; s0.awvalid = 1'b1; s0.awaddr = 32'h0;
        acc = 0; macc = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            a_hs = s0.awvalid && s0.awready;
            m_hs = m0.awvalid && m0.awready;
            od = m0.awaddr;
            if (m_hs) begin
                chk("aw_order", od, macc * 16);
                macc++;
            end
            if (a_hs) acc++;
            #1 s0.awaddr = acc * 16;
        end
        chk("lim_accepted", acc, 4);
        chk("lim_delivered", macc, 4);
        chk("lim_awready", s0.awready, 1'b0);
        chk("lim_at_limit", at_limit0, 1'b1);
        chk("lim_outstanding", outstanding0, 3'd4);

        // B at limit with AW pending: slot frees next cycle, 4 -> 3 -> 4
        push_b(4'h5, 2'b00);
        wait_s_b(found, aw_at, bid, bresp);
        chk("lim_aw_blocked_on_b_edge", aw_at, 1'b0);
        chk("lim_b_id", bid, 4'h5);
        chk("lim_freed_outstanding", outstanding0, 3'd3);
        chk("lim_freed_at_limit", at_limit0, 1'b0);
        chk("lim_freed_awready", s0.awready, 1'b1);
        @(posedge clk);
        a_hs = s0.awvalid && s0.awready;
        #1;
        s0.awvalid = 1'b0;
        chk("lim_fifth_accepted", a_hs, 1'b1);
        chk("lim_refill_outstanding", outstanding0, 3'd4);
        chk("lim_refill_at_limit", at_limit0, 1'b1);

        // below the limit, AW and B on the same edge leave the count alone
        s0.bready = 1'b1;
        push_b(4'h6, 2'b00);
        wait_s_b(found, aw_at, bid, bresp);
        s0.bready = 1'b0;
        chk("drain_outstanding", outstanding0, 3'd3);
        push_b(4'h7, 2'b00);
        chk("both_pre_awready", s0.awready, 1'b1);
        chk("both_pre_bvalid", s0.bvalid, 1'b1);
        s0.awvalid = 1'b1; s0.bready = 1'b1;
        @(posedge clk);
        both = s0.awvalid && s0.awready && s0.bvalid && s0.bready;
        #1;
        s0.awvalid = 1'b0; s0.bready = 1'b0;
        chk("both_handshake", both, 1'b1);
        chk("both_outstanding", outstanding0, 3'd3);
        chk("both_at_limit", at_limit0, 1'b0);

        // skid W under random downstream ready
        sent = 0; got = 0; comb_viol = 0;
        @(posedge clk);
        #1;
        s0.wvalid = 1'b1; s0.wdata = 32'd0;
        for (int c = 0; c < 6000 && got < 1000; c++) begin
            @(posedge clk);
            in_hs = s0.wvalid && s0.wready;
            out_hs = m0.wvalid && m0.wready;
            od = m0.wdata;
            if (out_hs) begin
                chk("skid_order", od, got);
                got++;
            end
            if (in_hs) sent++;
            #1;
            s0.wvalid = (sent < 1000);
            s0.wdata = sent;
            rd = s0.wready;
            m0.wready = 1'($urandom_range(0, 1));
            #1;
            if (s0.wready !== rd) comb_viol++;
        end
        s0.wvalid = 1'b0;
        chk("skid_delivered", got, 1000);
        chk("skid_accepted", sent, 1000);
        chk("skid_ready_comb_path", comb_viol, 0);

        // fill skid and AW stage, then reset asynchronously
        @(posedge clk);
        #1;
        m0.wready = 1'b0; m0.awready = 1'b0;
        s0.wvalid = 1'b1; s0.wdata = 32'hABCD_0001;
        s0.awvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("full_skid_wready", s0.wready, 1'b0);
        chk("full_m_wvalid", m0.wvalid, 1'b1);
        chk("full_m_awvalid", m0.awvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m_awvalid", m0.awvalid, 1'b0);
        chk("midrst_m_wvalid", m0.wvalid, 1'b0);
        chk("midrst_s_bvalid", s0.bvalid, 1'b0);
        chk("midrst_s_awready", s0.awready, 1'b0);
        chk("midrst_s_wready", s0.wready, 1'b0);
        chk("midrst_m_bready", m0.bready, 1'b0);
        chk("midrst_outstanding", outstanding0, 3'd0);
        chk("midrst_at_limit", at_limit0, 1'b0);
        s0.wvalid = 1'b0; s0.awvalid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_s_awready", s0.awready, 1'b1);
        chk("rel_s_wready", s0.wready, 1'b1);
        chk("rel_m_bready", m0.bready, 1'b1);
        chk("rel_m_wvalid", m0.wvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
